// File: rtl/alu_iterative_pkg.sv
// Shared definitions for the iterative execute-stage ALU: operation codes,
// FSM state encoding and shift-kind encoding.
package alu_iterative_pkg;

   // Operation codes; must stay in step with alu_controller.
   localparam logic [3:0] ALUADD  = 4'h0;
   localparam logic [3:0] ALUSUB  = 4'h1;
   localparam logic [3:0] ALUXOR  = 4'h2;
   localparam logic [3:0] ALUOR   = 4'h3;
   localparam logic [3:0] ALUAND  = 4'h4;
   localparam logic [3:0] ALUSLL  = 4'h5;
   localparam logic [3:0] ALUSRL  = 4'h6;
   localparam logic [3:0] ALUSRA  = 4'h7;
   localparam logic [3:0] ALUSLT  = 4'h8;
   localparam logic [3:0] ALUSLTU = 4'h9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SH_LL = 2'd0,
      SH_RL = 2'd1,
      SH_RA = 2'd2
   } shift_e;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == ALUSLL) || (op == ALUSRL) || (op == ALUSRA);
   endfunction

   function automatic shift_e shift_kind(input logic [3:0] op);
      case (op)
         ALUSRL:  return SH_RL;
         ALUSRA:  return SH_RA;
         default: return SH_LL;
      endcase
   endfunction

endpackage

// File: rtl/alu_single_op.sv
// Single-cycle combinational ALU core: ADD/SUB/XOR/OR/AND/SLT/SLTU.
// Any other code (including shift codes) evaluates as ADD.
module alu_single_op
   import alu_iterative_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned AWIDTH = 4
) (
   input  logic [AWIDTH-1:0] aluop,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   output logic [WIDTH-1:0]  y
);

   // Operation select; undefined codes fall through to ADD like the controller.
   always_comb begin
      y = a + b;
      case (4'(aluop))
         ALUSUB:  y = a - b;
         ALUXOR:  y = a ^ b;
         ALUOR:   y = a | b;
         ALUAND:  y = a & b;
         ALUSLT: begin
            y    = '0;
            y[0] = ($signed(a) < $signed(b));
         end
         ALUSLTU: begin
            y    = '0;
            y[0] = (a < b);
         end
         default: y = a + b;
      endcase
   end

endmodule

// File: rtl/alu_iterative.sv
// Multi-cycle ALU: single-cycle ops via alu_single_op, shifts one bit per
// cycle. Valid/ready on both sides; DONE can hand off and accept in one cycle.
module alu_iterative
   import alu_iterative_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned AWIDTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [AWIDTH-1:0] aluop,
   input  logic [WIDTH-1:0]  op_a,
   input  logic [WIDTH-1:0]  op_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  result,
   output logic              zero
);

   localparam int unsigned CW = $clog2(WIDTH);

   state_e          state, state_nx;
   shift_e          kind_q, kind_nx;
   logic [WIDTH-1:0] res_q, res_nx;
   logic [CW-1:0]    cnt_q, cnt_nx;
   logic [WIDTH-1:0] op_res;
   logic [CW-1:0]    amt;
   logic             accept;

   function automatic logic [WIDTH-1:0] shift1(input shift_e k, input logic [WIDTH-1:0] v);
      case (k)
         SH_LL:   return {v[WIDTH-2:0], 1'b0};
         SH_RL:   return {1'b0, v[WIDTH-1:1]};
         default: return {v[WIDTH-1], v[WIDTH-1:1]};
      endcase
   endfunction

   alu_single_op #(
      .WIDTH  (WIDTH),
      .AWIDTH (AWIDTH)
   ) u_single_op (
      .aluop (aluop),
      .a     (op_a),
      .b     (op_b),
      .y     (op_res)
   );

   // Handshake decode; in_ready depends combinationally on out_ready.
   always_comb begin
      amt       = op_b[CW-1:0];
      in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
      accept    = in_valid && in_ready;
      out_valid = (state == ST_DONE);
      zero      = (res_q == '0);
      result    = res_q;
   end

   // Next-state: advance the shift or release the result, then let a new
   // accept override (this is what makes DONE->new op bubble-free).
   always_comb begin
      state_nx = state;
      res_nx   = res_q;
      cnt_nx   = cnt_q;
      kind_nx  = kind_q;
      case (state)
         ST_SHIFT: begin
            res_nx = shift1(kind_q, res_q);
            cnt_nx = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_nx = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) state_nx = ST_IDLE;
         end
         default: ;
      endcase
      if (accept) begin
         if (is_shift(4'(aluop))) begin
            kind_nx = shift_kind(4'(aluop));
            if (amt == '0) begin
               res_nx   = op_a;
               cnt_nx   = '0;
               state_nx = ST_DONE;
            end else begin
               res_nx   = shift1(kind_nx, op_a);
               cnt_nx   = amt - CW'(1);
               state_nx = (amt == CW'(1)) ? ST_DONE : ST_SHIFT;
            end
         end else begin
            res_nx   = op_res;
            cnt_nx   = '0;
            state_nx = ST_DONE;
         end
      end
   end

   // State, result, counter and latched shift kind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         res_q  <= '0;
         cnt_q  <= '0;
         kind_q <= SH_LL;
      end else begin
         state  <= state_nx;
         res_q  <= res_nx;
         cnt_q  <= cnt_nx;
         kind_q <= kind_nx;
      end
   end

endmodule

// File: tb/tb_alu_iterative.sv
// Scoreboard bench for alu_iterative: directed vectors with latency checks,
// backpressure, reset mid-shift and random back-to-back traffic.
module tb_alu_iterative;
   import alu_iterative_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  aluop;
   logic [31:0] op_a, op_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;

   typedef struct {
      logic [31:0] res;
      int unsigned acc;
      int unsigned lat;
      bit          chk_lat;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int          vectors = 0;
   int          errors = 0;
   bit          rand_done;

   alu_iterative #(
      .WIDTH  (32),
      .AWIDTH (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .aluop     (aluop),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      int unsigned n;
      n = int'(b[4:0]);
      case (op)
         ALUSUB:  return a - b;
         ALUXOR:  return a ^ b;
         ALUOR:   return a | b;
         ALUAND:  return a & b;
         ALUSLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALUSLTU: return (a < b) ? 32'd1 : 32'd0;
         ALUSLL:  return a << n;
         ALUSRL:  return a >> n;
         ALUSRA:  return 32'($signed(a) >>> n);
         default: return a + b;
      endcase
   endfunction

   function automatic int unsigned model_lat(input logic [3:0] op, input logic [31:0] b);
      int unsigned n;
      n = int'(b[4:0]);
      if (op == ALUSLL || op == ALUSRL || op == ALUSRA) return (n <= 1) ? 1 : n;
      return 1;
   endfunction

   // Called at a negedge; returns at the negedge following acceptance.
   task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, input int unsigned lat, input bit chkl);
      int guard;
      exp_t e;
      in_valid = 1'b1;
      aluop    = op;
      op_a     = a;
      op_b     = b;
      #1;
      guard = 0;
      while (!in_ready && guard < 300) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (!in_ready) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
      e.res     = expv;
      e.acc     = cyc;
      e.lat     = lat;
      e.chk_lat = chkl;
      sb.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      chk("drain", sb.size(), 32'd0);
   endtask

   // Output monitor: pops on each handshake, flags any unexpected valid.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
               chk("spurious_valid", {31'd0, out_valid}, 32'd0);
            end else if (out_ready) begin
               e = sb.pop_front();
               chk("result", result, e.res);
               chk("zero", {31'd0, zero}, {31'd0, (e.res == 32'd0)});
               if (e.chk_lat) chk("latency", cyc - e.acc, e.lat);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [3:0]  rop;
      logic [31:0] ra, rb;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      aluop     = '0;
      op_a      = '0;
      op_b      = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_zero", {31'd0, zero}, 32'd1);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vectors, back to back, out_ready held high.
      send(ALUADD,  32'd5,        32'd7,  32'd12,         1,  1'b1);
      send(ALUSUB,  32'd3,        32'd5,  32'hFFFF_FFFE,  1,  1'b1);
      send(ALUSUB,  32'd9,        32'd9,  32'd0,          1,  1'b1);
      send(ALUSRA,  32'h8000_0000, 32'd4, 32'hF800_0000,  4,  1'b1);
      send(ALUSRL,  32'h8000_0000, 32'd4, 32'h0800_0000,  4,  1'b1);
      send(ALUSLL,  32'd1,        32'd31, 32'h8000_0000,  31, 1'b1);
      send(ALUSLL,  32'h1234,     32'd0,  32'h1234,       1,  1'b1);
      send(ALUSRL,  32'h10,       32'd1,  32'h8,          1,  1'b1);
      send(ALUSLL,  32'h3,        32'd2,  32'hC,          2,  1'b1);
      send(ALUSLT,  32'hFFFF_FFFF, 32'd1, 32'd1,          1,  1'b1);
      send(ALUSLTU, 32'hFFFF_FFFF, 32'd1, 32'd0,          1,  1'b1);
      send(4'hF,    32'd2,        32'd3,  32'd5,          1,  1'b1);
      send(ALUAND,  32'hF0F0,     32'h0FF0, 32'h00F0,     1,  1'b1);
      drain();

      // Backpressure: result held and in_ready low while out_ready is low.
      out_ready = 1'b0;
      send(ALUADD, 32'd100, 32'd23, 32'd123, 1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_result", result, 32'd123);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      send(ALUXOR, 32'hAAAA_0000, 32'h5555_FFFF, 32'hFFFF_FFFF, 1, 1'b1);
      #1;
      chk("handoff_valid", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
      drain();

      // Reset during a long shift: nothing emitted afterwards.
      send(ALUSLL, 32'd1, 32'd31, 32'h8000_0000, 31, 1'b1);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_result", result, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      #1;
      chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
      @(negedge clk);

      // Random traffic with random backpressure.
      rand_done = 1'b0;
      fork
         begin
            for (int k = 0; k < 80; k++) begin
               rop = 4'($urandom_range(0, 15));
               ra  = $urandom;
               rb  = $urandom;
               if ($urandom_range(0, 3) == 0) rb[4:0] = 5'($urandom_range(0, 2));
               if ($urandom_range(0, 5) == 0) rb = ra;
               send(rop, ra, rb, model(rop, ra, rb), model_lat(rop, rb), 1'b0);
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(negedge clk);
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/alu_iterative.md
# alu_iterative

Multi-cycle execute-stage ALU that consumes the 4-bit `aluop` produced by `alu_controller` together with two register/immediate operands. Add, sub, logic and compare complete in one cycle. Shifts run one bit position per cycle to keep the datapath small on the target FPGA. Valid/ready handshakes on both sides let the pipeline stall cleanly around long shifts.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width.
- `AWIDTH`, 4: `aluop` width; must match `alu_controller`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  upstream presents `aluop`, `op_a`, `op_b`.
- `in_ready`  out  1  block can accept an operation this cycle.
- `aluop`  in  AWIDTH  operation code, `ALU*` macros from `alu_defines.v`.
- `op_a`  in  WIDTH  first operand; the shifted value for shifts.
- `op_b`  in  WIDTH  second operand; the low `$clog2(WIDTH)` bits are the shift amount.
- `out_valid`  out  1  `result` and `zero` are valid.
- `out_ready`  in  1  downstream accepts the result.
- `result`  out  WIDTH  registered result.
- `zero`  out  1  `result == 0`; used by branch logic.

## Operation
- States: IDLE, SHIFT, DONE.
- Accept condition: `in_valid && in_ready`.
- `in_ready` = (state==IDLE) || (state==DONE && out_ready). It is combinational on `out_ready` and allows back-to-back operations.
- Operations on accept:
  - ADD: a+b, modulo 2^WIDTH.
  - SUB: a−b, modulo 2^WIDTH.
  - XOR, OR, AND: bitwise.
  - SLT: signed a<b gives 1, otherwise 0.
  - SLTU: unsigned compare, same result encoding as SLT.
  - Any undefined code: executes as ADD, matching the controller default.
  - All of the above load `result` and go to DONE.
- Shifts (SLL/SRL/SRA), with n = `op_b[$clog2(WIDTH)-1:0]`:
  - n=0: `result` ← `op_a`; go to DONE.
  - n≥1: `result` ← `op_a` shifted by 1; counter ← n−1. Go to DONE if the counter is 0, otherwise to SHIFT.
  - SHIFT: shift `result` by 1 each cycle and decrement the counter. Move to DONE on the cycle the counter goes 1→0.
  - SRA fills with the current MSB. SLL and SRL fill with 0.
- The shift kind is latched at accept. `aluop`, `op_a` and `op_b` are don't-care after acceptance.
- DONE: `out_valid`=1, and `result`/`zero` are held stable until `out_valid && out_ready`.
- On that handshake, the block goes to IDLE, or directly re-accepts a new operation if `in_valid` is also high.
- Reset (async, any state):
  - state=IDLE, `out_valid`=0, `result`=0, `zero`=1, counter=0.
  - An in-flight operation is discarded; nothing is emitted.

## Timing
- Accept at edge E.
- Non-shift ops and shifts with n≤1: `out_valid` is high in the cycle after E (latency 1).
- Shift with n≥2: `out_valid` rises after edge E+n−1 (latency n).
- Maximum latency is WIDTH−1 cycles.
- Throughput with `out_ready` held high: one operation per latency cycle. There is no bubble, because DONE can hand off and accept in the same cycle.
- `in_ready` is low throughout SHIFT, and low in DONE while `out_ready`=0.
- `out_valid` never drops without a handshake or reset.
- All outputs are registered except `in_ready` and `zero`. `zero` is combinational from the `result` register.

## Structure
- `alu_defines.v` (shared): `ALUADD`…`ALUSLTU` codes; the block relies only on the macro names.
- State encoding: localparams inside the module.
- One sub-module, `alu_single_op`: purely combinational ADD/SUB/XOR/OR/AND/SLT/SLTU on `WIDTH`-bit operands, reusable by a future single-cycle core.
- The shifter step and FSM stay in `alu_iterative`.

## Test plan
- ADD 5+7, `out_ready`=1 → `out_valid` one cycle after accept, `result`=12, `zero`=0. SUB 3−5 → 0xFFFFFFFE. SUB 9−9 → `zero`=1.
- SRA 0x80000000 by 4 → `result`=0xF8000000 with `out_valid` 4 cycles after accept. SRL of the same operands → 0x08000000. SLL 1 by 31 → 0x80000000 after 31 cycles.
- SLL 0x1234 by 0 → latency 1, `result`=0x1234. SLT −1 vs 1 → 1. SLTU −1 vs 1 → 0. Undefined code 0xF with 2,3 → 5.
- Backpressure: hold `out_ready`=0 for 3 cycles in DONE → `result` stable and `in_ready`=0. Then `out_ready`=1 with `in_valid`=1 → handoff and new accept in the same cycle, `out_valid` stays high.
- Assert `rst_n`=0 mid-SHIFT → next sampled: `out_valid`=0, `result`=0, `in_ready`=1. No stale result appears after release.
- Random back-to-back ops with random `out_ready` → results match a reference model, in order, with no drops or duplicates.
